// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - command encoding and circular pointer helpers for the LIFO stack
package stack_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 3'd0,
    CMD_PUSH  = 3'd1,
    CMD_POP   = 3'd2,
    CMD_GET   = 3'd3,
    CMD_CLEAR = 3'd4
  } cmd_e;

  // Advance a pointer by one slot, wrapping DEPTH-1 back to 0 by explicit compare
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

  // Step a pointer back by one slot, wrapping 0 to DEPTH-1 by explicit compare
  function automatic int unsigned wrap_dec(input int unsigned p, input int unsigned depth);
    return (p == 0) ? depth - 1 : p - 1;
  endfunction

endpackage

// File: rtl/stack_mem_array.sv
// rtl/stack_mem_array.sv - DEPTH x WIDTH register array, one write port, one async read port
module stack_mem_array #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: zeroed on reset, otherwise one word written per cycle when enabled
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read is combinational; the caller registers the result
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack_param.sv
// rtl/lifo_stack_param.sv - parametrised circular LIFO stack with registered read port and flags
module lifo_stack_param
  import stack_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 5,
  parameter int OVERWRITE = 1,
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [CMD_W-1:0] COMMAND,
  input  logic [IW-1:0]    INDEX,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             OUT_VALID,
  output logic             ERR,
  output logic [IW:0]      COUNT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam logic [IW:0]   DEPTH_C = (IW+1)'(DEPTH);
  localparam logic [IW+1:0] DEPTH_W = (IW+2)'(DEPTH);

  logic [IW-1:0]    top_q;
  logic [IW:0]      count_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             err_q;

  logic [IW-1:0]    top_inc;
  logic [IW-1:0]    top_dec;
  logic [IW+1:0]    get_sum;
  logic [IW+1:0]    get_wrap;
  logic [IW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             get_ok;
  logic             mem_we;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign top_inc = IW'(wrap_inc(32'(top_q), DEPTH));
  assign top_dec = IW'(wrap_dec(32'(top_q), DEPTH));

  // DEPTH is added before subtracting so the GET slot never underflows; one
  // conditional subtract brings it back into 0..DEPTH-1 when INDEX < COUNT.
  assign get_sum  = {2'b00, top_q} + DEPTH_W - (IW+2)'(1) - {2'b00, INDEX};
  assign get_wrap = (get_sum >= DEPTH_W) ? (get_sum - DEPTH_W) : get_sum;

  assign rd_addr = (COMMAND == CMD_GET) ? get_wrap[IW-1:0] : top_dec;
  assign get_ok  = ({1'b0, INDEX} < count_q);
  assign push_ok = !full || (OVERWRITE != 0);
  assign mem_we  = (COMMAND == CMD_PUSH) && push_ok;

  stack_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .CLK     (CLK),
    .RESET   (RESET),
    .we_i    (mem_we),
    .waddr_i (top_q),
    .wdata_i (DATA_IN),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Pointer, occupancy and registered read/status updates, one command per cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      top_q   <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (COMMAND)
        CMD_PUSH: begin
          if (push_ok) begin
            top_q <= top_inc;
            if (!full) begin
              count_q <= count_q + (IW+1)'(1);
            end
          end else begin
            err_q <= 1'b1;
          end
        end
        CMD_POP: begin
          if (!empty) begin
            dout_q  <= rd_data;
            top_q   <= top_dec;
            count_q <= count_q - (IW+1)'(1);
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        CMD_GET: begin
          if (get_ok) begin
            dout_q  <= rd_data;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        CMD_CLEAR: begin
          top_q   <= '0;
          count_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign DATA_OUT  = dout_q;
  assign OUT_VALID = valid_q;
  assign ERR       = err_q;
  assign COUNT     = count_q;
  assign FULL      = full;
  assign EMPTY     = empty;

endmodule

// File: tb/tb_lifo_stack_param.sv
// tb/tb_lifo_stack_param.sv - table-driven self-checking bench for lifo_stack_param
module tb_lifo_stack_param;
  import stack_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] COMMAND = 3'd0;
  logic [2:0] INDEX = 3'd0;
  logic [3:0] DATA_IN = 4'd0;

  logic [3:0] dout_a, dout_b;
  logic       valid_a, valid_b, err_a, err_b, full_a, full_b, empty_a, empty_b;
  logic [3:0] count_a, count_b;

  int total = 0;
  int passed = 0;

  typedef struct {
    bit         rst;
    logic [2:0] cmd;
    logic [2:0] idx;
    logic [3:0] din;
    logic [3:0] dout;
    bit         valid;
    bit         err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  lifo_stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(1)) dut_ow (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .DATA_IN(DATA_IN),
    .DATA_OUT(dout_a), .OUT_VALID(valid_a), .ERR(err_a), .COUNT(count_a),
    .FULL(full_a), .EMPTY(empty_a)
  );

  lifo_stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(0)) dut_rj (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .DATA_IN(DATA_IN),
    .DATA_OUT(dout_b), .OUT_VALID(valid_b), .ERR(err_b), .COUNT(count_b),
    .FULL(full_b), .EMPTY(empty_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input bit r, input logic [2:0] c, input logic [2:0] ix, input logic [3:0] d,
                     input logic [3:0] ed, input bit ev, input bit ee, input logic [3:0] ec);
    vecs.push_back('{r, c, ix, d, ed, ev, ee, ec});
  endtask

  task automatic rst_pulse();
    RESET = 1'b1;
    COMMAND = 3'd0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic step(input logic [2:0] c, input logic [2:0] ix, input logic [3:0] d);
    COMMAND = c;
    INDEX = ix;
    DATA_IN = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // stack basics and GET
    add(1, 0, 0, 0,  0, 0, 0, 0);
    add(0, CMD_PUSH, 0, 1,  0, 0, 0, 1);
    add(0, CMD_PUSH, 0, 2,  0, 0, 0, 2);
    add(0, CMD_PUSH, 0, 3,  0, 0, 0, 3);
    add(0, CMD_GET,  0, 0,  3, 1, 0, 3);
    add(0, CMD_GET,  2, 0,  1, 1, 0, 3);
    add(0, CMD_GET,  3, 0,  1, 0, 1, 3);
    // overwrite-oldest when full
    add(1, 0, 0, 0,  0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, CMD_PUSH, 0, 4'(i), 0, 0, 0, 4'((i > 5) ? 5 : i));
    for (int i = 0; i < 5; i++) add(0, CMD_POP, 0, 0, 4'(7 - i), 1, 0, 4'(4 - i));
    add(0, CMD_POP, 0, 0,  3, 0, 1, 0);
    // pointer wrap
    add(1, 0, 0, 0,  0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, CMD_PUSH, 0, 4'(i), 0, 0, 0, 4'(i));
    for (int i = 0; i < 3; i++) add(0, CMD_POP, 0, 0, 4'(4 - i), 1, 0, 4'(3 - i));
    for (int i = 0; i < 4; i++) add(0, CMD_PUSH, 0, 4'(10 + i), 2, 0, 0, 4'(2 + i));
    for (int i = 0; i < 4; i++) add(0, CMD_GET, 3'(i), 0, 4'(13 - i), 1, 0, 5);
    add(0, CMD_GET,  4, 0,  1, 1, 0, 5);
    add(0, CMD_GET,  5, 0,  1, 0, 1, 5);
    add(0, CMD_GET,  7, 0,  1, 0, 1, 5);
    // clear, hold and undefined commands
    add(1, 0, 0, 0,  0, 0, 0, 0);
    add(0, CMD_PUSH, 0, 1,  0, 0, 0, 1);
    add(0, CMD_PUSH, 0, 2,  0, 0, 0, 2);
    add(0, CMD_PUSH, 0, 3,  0, 0, 0, 3);
    add(0, CMD_GET,  0, 0,  3, 1, 0, 3);
    add(0, CMD_CLEAR, 0, 0, 3, 0, 0, 0);
    add(0, CMD_POP,  0, 0,  3, 0, 1, 0);
    add(0, CMD_PUSH, 0, 8,  3, 0, 0, 1);
    add(0, CMD_POP,  0, 0,  8, 1, 0, 0);
    add(0, CMD_NOP,  0, 5,  8, 0, 0, 0);
    add(0, 3'd7,     0, 5,  8, 0, 0, 0);

    rst_pulse();
    foreach (vecs[i]) begin
      if (vecs[i].rst) rst_pulse();
      else step(vecs[i].cmd, vecs[i].idx, vecs[i].din);
      chk($sformatf("v%0d dout", i),  32'(dout_a),  32'(vecs[i].dout));
      chk($sformatf("v%0d valid", i), 32'(valid_a), 32'(vecs[i].valid));
      chk($sformatf("v%0d err", i),   32'(err_a),   32'(vecs[i].err));
      chk($sformatf("v%0d count", i), 32'(count_a), 32'(vecs[i].cnt));
      chk($sformatf("v%0d full", i),  32'(full_a),  32'(vecs[i].cnt == 4'd5));
      chk($sformatf("v%0d empty", i), 32'(empty_a), 32'(vecs[i].cnt == 4'd0));
    end

    // reject policy against overwrite policy on identical stimulus
    rst_pulse();
    for (int i = 1; i <= 5; i++) step(CMD_PUSH, 0, 4'(i));
    chk("rej full", 32'(full_b), 32'd1);
    step(CMD_PUSH, 0, 9);
    chk("rej err", 32'(err_b), 32'd1);
    chk("rej count", 32'(count_b), 32'd5);
    chk("ow no err", 32'(err_a), 32'd0);
    chk("ow count", 32'(count_a), 32'd5);
    step(CMD_POP, 0, 0);
    chk("rej pop dout", 32'(dout_b), 32'd5);
    chk("rej pop valid", 32'(valid_b), 32'd1);
    chk("rej pop count", 32'(count_b), 32'd4);
    chk("ow pop dout", 32'(dout_a), 32'd9);

    // asynchronous reset in the middle of a PUSH
    rst_pulse();
    for (int i = 1; i <= 4; i++) step(CMD_PUSH, 0, 4'(i));
    step(CMD_GET, 0, 0);
    chk("pre-rst dout", 32'(dout_a), 32'd4);
    chk("pre-rst count", 32'(count_a), 32'd4);
    COMMAND = CMD_PUSH;
    DATA_IN = 4'd5;
    #2;
    RESET = 1'b1;
    #1;
    chk("async count", 32'(count_a), 32'd0);
    chk("async dout", 32'(dout_a), 32'd0);
    chk("async empty", 32'(empty_a), 32'd1);
    chk("async count b", 32'(count_b), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    step(CMD_GET, 0, 0);
    chk("post-rst get err", 32'(err_a), 32'd1);
    chk("post-rst get valid", 32'(valid_a), 32'd0);
    chk("post-rst get dout", 32'(dout_a), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
